// File: rtl/overlap_scanner.sv
// Stores up to MAX_BOXES boxes per frame and reports every overlapping (newer, older) pair.
// Box n takes n+2 cycles from accept to the next in_ready; pair output stalls the scan until out_ready.
module overlap_scanner #(
  parameter int COORD_W   = 8,
  parameter int MAX_BOXES = 8,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COORD_W-1:0]   in_x,
  input  logic [COORD_W-1:0]   in_y,
  input  logic [COORD_W-1:0]   in_w,
  input  logic [COORD_W-1:0]   in_h,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx_a,
  output logic [IDX_W-1:0]     out_idx_b,
  output logic                 done,
  output logic [2*IDX_W-1:0]   pair_count,
  output logic                 overflow
);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } box_t;

  typedef enum logic [1:0] {ACCEPT, SCAN, EMIT, FINISH} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  box_t                 r_mem [MAX_BOXES];
  logic [IDX_W:0]       r_cnt;
  logic [IDX_W-1:0]     r_i;
  logic                 r_last;
  logic [2*IDX_W-1:0]   r_pairs;
  logic                 r_ovf;

  logic [IDX_W-1:0]     w_n;
  logic                 w_full;
  logic                 w_scan_end;
  logic                 w_hit;
  box_t                 w_a;
  box_t                 w_b;
  logic [COORD_W:0]     w_ax_end;
  logic [COORD_W:0]     w_ay_end;
  logic [COORD_W:0]     w_bx_end;
  logic [COORD_W:0]     w_by_end;

  assign w_n        = r_cnt[IDX_W-1:0];
  assign w_full     = (r_cnt == (IDX_W+1)'(MAX_BOXES));
  assign w_scan_end = (r_i == w_n);

  // Box under test (a) against stored box (b); far edges get one extra bit so they never wrap.
  assign w_a      = r_mem[w_n];
  assign w_b      = r_mem[r_i];
  assign w_ax_end = {1'b0, w_a.x} + {1'b0, w_a.w};
  assign w_ay_end = {1'b0, w_a.y} + {1'b0, w_a.h};
  assign w_bx_end = {1'b0, w_b.x} + {1'b0, w_b.w};
  assign w_by_end = {1'b0, w_b.y} + {1'b0, w_b.h};
  assign w_hit    = (|w_a.w) && (|w_a.h) && (|w_b.w) && (|w_b.h) &&
                    ({1'b0, w_a.x} < w_bx_end) && ({1'b0, w_b.x} < w_ax_end) &&
                    ({1'b0, w_a.y} < w_by_end) && ({1'b0, w_b.y} < w_ay_end);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    case (r_state)
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_full) w_state_nxt = in_last ? FINISH : ACCEPT;
          else        w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (w_scan_end) w_state_nxt = r_last ? FINISH : ACCEPT;
        else if (w_hit) w_state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = SCAN;
      end
      FINISH: begin
        done        = 1'b1;
        w_state_nxt = ACCEPT;
      end
      default: w_state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCEPT;
      r_cnt   <= '0;
      r_i     <= '0;
      r_last  <= 1'b0;
      r_pairs <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ACCEPT: begin
          if (in_valid) begin
            if (w_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_i    <= '0;
              r_last <= in_last;
            end
          end
        end
        SCAN: begin
          if (w_scan_end)  r_cnt <= r_cnt + (IDX_W+1)'(1);
          else if (!w_hit) r_i   <= r_i + IDX_W'(1);
        end
        EMIT: begin
          if (out_ready) begin
            r_pairs <= r_pairs + (2*IDX_W)'(1);
            r_i     <= r_i + IDX_W'(1);
          end
        end
        FINISH: begin
          r_cnt   <= '0;
          r_i     <= '0;
          r_pairs <= '0;
        end
        default: ;
      endcase
    end
  end

  // Box storage carries no reset; entries are only read after being written this frame.
  always_ff @(posedge clk) begin
    if (r_state == ACCEPT && in_valid && !w_full)
      r_mem[w_n] <= '{x: in_x, y: in_y, w: in_w, h: in_h};
  end

  assign out_idx_a  = w_n;
  assign out_idx_b  = r_i;
  assign pair_count = r_pairs;
  assign overflow   = r_ovf;

endmodule

// File: doc/overlap_scanner.md
OVERLAP_SCANNER -- requirements
Module: overlap_scanner

Interface
REQ-001 The module SHALL have parameter COORD_W, default 8, meaning the bit width of box x, y, width and height.
REQ-002 The module SHALL have parameter MAX_BOXES, default 8, meaning the number of boxes stored per frame (power of two, at least 2).
REQ-003 The module SHALL have parameter IDX_W, default 3, meaning the box index width, equal to log2(MAX_BOXES).
REQ-004 The module SHALL have the following ports, clock and reset first:
  - clk  input  1  the single clock; all logic on its rising edge.
  - rst  input  1  reset, synchronous and active-high.
  - in_valid  input  1  box offer valid.
  - in_ready  output  1  box accept ready.
  - in_x  input  COORD_W  box left edge.
  - in_y  input  COORD_W  box bottom edge.
  - in_w  input  COORD_W  box width.
  - in_h  input  COORD_W  box height.
  - in_last  input  1  the offered box is the last box of its frame.
  - out_valid  output  1  overlap pair valid.
  - out_ready  input  1  overlap pair consumed.
  - out_idx_a  output  IDX_W  index of the newer box.
  - out_idx_b  output  IDX_W  index of the older box.
  - done  output  1  one-cycle pulse marking end of frame.
  - pair_count  output  IDX_W*2  number of pairs emitted this frame; valid while done is high.
  - overflow  output  1  sticky flag: a frame offered more than MAX_BOXES boxes.

Function
REQ-005 Overlap SHALL use half-open intervals: boxes A and B overlap iff Ax < Bx+Bw, Bx < Ax+Aw, Ay < By+Bh and By < Ay+Ah; touching edges do not overlap.
REQ-006 Edge sums SHALL be computed at COORD_W+1 bits with no wrap-around.
REQ-007 A box of zero width or zero height SHALL never overlap anything.
REQ-008 The FSM SHALL have states ACCEPT, SCAN, EMIT and FINISH.
REQ-009 In ACCEPT, in_ready SHALL be 1; a box is accepted when in_valid and in_ready are both 1.
REQ-010 An accepted box SHALL be stored at index n, where n is the current box count, and the FSM SHALL go to SCAN with scan pointer i=0.
REQ-011 SCAN SHALL compare box n against stored box i, one comparison per cycle, for i = 0 up to n-1 in ascending order.
REQ-012 On a hit, SCAN SHALL go to EMIT; out_valid=1, out_idx_a=n, out_idx_b=i; out_valid and the indices SHALL hold stable until out_ready=1.
REQ-013 On the out_valid and out_ready handshake, pair_count SHALL increment and the FSM SHALL resume SCAN at i+1.
REQ-014 When i reaches n, the box count SHALL increment; if the box carried in_last the FSM SHALL go to FINISH, otherwise to ACCEPT.
REQ-015 For n=0, SCAN SHALL take exactly one cycle with no comparisons.
REQ-016 in_ready SHALL be 0 in SCAN, EMIT and FINISH.
REQ-017 FINISH SHALL last one cycle with done=1 and pair_count showing the frame total, then clear the box count and pair_count and return to ACCEPT.
REQ-018 If a box is accepted while the box count equals MAX_BOXES, it SHALL be discarded without scanning and overflow SHALL set to 1.
  - If that discarded box carries in_last, the FSM SHALL go to FINISH.
REQ-019 overflow SHALL clear only on rst.
REQ-020 Latency SHALL be n+2 cycles from acceptance of box n to the next in_ready=1, plus any cycles out_valid waits for out_ready.

Reset
REQ-021 While rst=1 at a clock edge, the FSM SHALL enter ACCEPT and clear the box count, pair_count and overflow.
REQ-022 Reset values SHALL be in_ready=1, out_valid=0, out_idx_a=0, out_idx_b=0, done=0, pair_count=0, overflow=0.
REQ-023 Reset asserted during SCAN or EMIT SHALL abort the frame, and any pending pair SHALL be dropped.
REQ-024 Stored box contents SHALL not require reset.

Verification
REQ-025 The bench SHALL cover these directed scenarios (all boxes 80x80, out_ready=1 unless stated):
  - (0,0) then (0,40, last) -> one pair a=1, b=0; done with pair_count=1.
  - (0,0), (40,0, last) -> one pair a=1, b=0.
  - (0,0), (0,80), (80,0), (80,80, last) -> no pairs; done with pair_count=0.
  - (0,0), (0,40), (0,80, last) -> pairs (1,0) then (2,1), not (2,0); pair_count=2.
  - (0,0), (0,40), (120,120, last) with out_ready held 0 for 5 cycles -> out_valid and pair (1,0) held stable; in_ready=0 throughout; pair_count=1.
  - 9 boxes at (0,0) with the 9th marked last -> overflow=1 and pair_count=28; rst during EMIT -> in_ready=1 and out_valid=0 on the next cycle.
